// File: rtl/mealy_pkg.sv
// Shared constants and helpers for the parametrised Mealy sequence detector.
package mealy_pkg;

   localparam int unsigned OVERLAP_OFF = 0;
   localparam int unsigned OVERLAP_ON  = 1;

   localparam int unsigned DEF_PATTERN_W = 3;
   localparam logic [DEF_PATTERN_W-1:0] DEF_PATTERN = 3'b101;
   localparam int unsigned DEF_COUNT_W   = 8;

   // Ceiling log2 for elaboration-time width sizing (v >= 2).
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/seq_hist_shift.sv
// Enable-gated history shift register with saturating fill counter and
// synchronous restart; newest bit enters at the LSB.
module seq_hist_shift
   import mealy_pkg::*;
#(
   parameter int unsigned PATTERN_W = DEF_PATTERN_W
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          en,
   input  logic                          w,
   input  logic                          restart,
   output logic [PATTERN_W-2:0]          hist,
   output logic [clog2(PATTERN_W)-1:0]   fill
);

   localparam int unsigned HIST_W = PATTERN_W - 1;
   localparam int unsigned FILL_W = clog2(PATTERN_W);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_W - 1);

   // Restart wins over shifting so a consumed match leaves no residue.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist <= '0;
         fill <= '0;
      end else if (en) begin
         if (restart) begin
            hist <= '0;
            fill <= '0;
         end else begin
            hist <= HIST_W'({hist, w});
            if (fill != FILL_MAX) fill <= fill + FILL_W'(1);
         end
      end
   end

endmodule

// File: rtl/mealy_seq_detector.sv
// Parametrised Mealy serial-pattern detector with overlap/non-overlap modes.
// Optional saturating match counter enabled by defining MATCH_COUNT_EN.
module mealy_seq_detector
   import mealy_pkg::*;
#(
   parameter int unsigned              PATTERN_W = DEF_PATTERN_W,
   parameter logic [PATTERN_W-1:0]     PATTERN   = PATTERN_W'(DEF_PATTERN),
   parameter int unsigned              OVERLAP   = OVERLAP_ON
`ifdef MATCH_COUNT_EN
   ,
   parameter int unsigned              COUNT_W   = DEF_COUNT_W
`endif
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          en,
   input  logic                          w,
   output logic                          z,
   output logic                          z_q,
   output logic [clog2(PATTERN_W)-1:0]   fill
`ifdef MATCH_COUNT_EN
   ,
   input  logic                          count_clr,
   output logic [COUNT_W-1:0]            match_count
`endif
);

   localparam int unsigned FILL_W = clog2(PATTERN_W);

   logic [PATTERN_W-2:0] hist;
   logic                 restart;

   seq_hist_shift #(
      .PATTERN_W (PATTERN_W)
   ) u_hist (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .w       (w),
      .restart (restart),
      .hist    (hist),
      .fill    (fill)
   );

   // Full history gating keeps an all-zero pattern from matching the reset state.
   assign z = en & ~reset & (fill == FILL_W'(PATTERN_W - 1)) & ({hist, w} == PATTERN);

   assign restart = z & (OVERLAP == OVERLAP_OFF);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) z_q <= 1'b0;
      else       z_q <= z;
   end

`ifdef MATCH_COUNT_EN
   // Clear has priority over a coincident increment; count saturates.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                          match_count <= '0;
      else if (count_clr)                 match_count <= '0;
      else if (z && (match_count != '1))  match_count <= match_count + COUNT_W'(1);
   end
`endif

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Scoreboard bench for mealy_seq_detector: overlap and non-overlap instances
// share stimulus; counter checks are built when MATCH_COUNT_EN is defined.
module tb_mealy_seq_detector;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       w;
   logic       z_o, zq_o, z_n, zq_n;
   logic [1:0] fill_o, fill_n;
`ifdef MATCH_COUNT_EN
   logic       count_clr;
   logic [1:0] mc_o;
   logic [7:0] mc_n;
`endif

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic       zo;
      logic       zn;
      logic [1:0] fo;
      logic [1:0] fn;
   } exp_t;

   exp_t sb[$];
   exp_t x;

   always #5 clk = ~clk;

   mealy_seq_detector #(
      .PATTERN_W (3),
      .PATTERN   (3'b101),
      .OVERLAP   (1)
`ifdef MATCH_COUNT_EN
      ,
      .COUNT_W   (2)
`endif
   ) u_ov (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .w           (w),
      .z           (z_o),
      .z_q         (zq_o),
      .fill        (fill_o)
`ifdef MATCH_COUNT_EN
      ,
      .count_clr   (count_clr),
      .match_count (mc_o)
`endif
   );

   mealy_seq_detector #(
      .PATTERN_W (3),
      .PATTERN   (3'b101),
      .OVERLAP   (0)
   ) u_no (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .w           (w),
      .z           (z_n),
      .z_q         (zq_n),
      .fill        (fill_n)
`ifdef MATCH_COUNT_EN
      ,
      .count_clr   (count_clr),
      .match_count (mc_n)
`endif
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One enabled/disabled bit: z and fill checked before the edge, z_q after it.
   task automatic step(input logic e, input logic b, input logic zo, input logic zn,
                       input logic [1:0] fo, input logic [1:0] fn);
      exp_t y;
      @(negedge clk);
      en = e;
      w  = b;
      sb.push_back('{zo, zn, fo, fn});
      #1;
      y = sb.pop_front();
      chk("z_ovl",    8'(z_o),    8'(y.zo));
      chk("z_novl",   8'(z_n),    8'(y.zn));
      chk("fill_ovl", 8'(fill_o), 8'(y.fo));
      chk("fill_novl",8'(fill_n), 8'(y.fn));
      @(posedge clk);
      #1;
      chk("zq_ovl",   8'(zq_o),   8'(y.zo));
      chk("zq_novl",  8'(zq_n),   8'(y.zn));
   endtask

   // Reset pulse with en=1/w=1 applied while reset is high: z must stay low.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      en    = 1'b1;
      w     = 1'b1;
      #1;
      chk("rst_z_ovl",    8'(z_o),    8'h00);
      chk("rst_z_novl",   8'(z_n),    8'h00);
      chk("rst_fill_ovl", 8'(fill_o), 8'h00);
      chk("rst_fill_novl",8'(fill_n), 8'h00);
      en = 1'b0;
      w  = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      en    = 1'b0;
      w     = 1'b0;
`ifdef MATCH_COUNT_EN
      count_clr = 1'b0;
`endif
      #2;
      chk("init_z",    8'(z_o),    8'h00);
      chk("init_zq",   8'(zq_o),   8'h00);
      chk("init_fill", 8'(fill_o), 8'h00);
      chk("init_filln",8'(fill_n), 8'h00);
      @(negedge clk);
      reset = 1'b0;

      // 1,0,1,0,1,0: overlap matches bits 3 and 5, non-overlap bit 3 only
      step(1, 1, 0, 0, 2'd0, 2'd0);
      step(1, 0, 0, 0, 2'd1, 2'd1);
      step(1, 1, 1, 1, 2'd2, 2'd2);
      step(1, 0, 0, 0, 2'd2, 2'd0);
      step(1, 1, 1, 0, 2'd2, 2'd1);
      step(1, 0, 0, 0, 2'd2, 2'd2);

      // Reset mid-pattern loses the partial 1,0
      do_reset();
      step(1, 1, 0, 0, 2'd0, 2'd0);
      step(1, 0, 0, 0, 2'd1, 2'd1);
      do_reset();
      step(1, 1, 0, 0, 2'd0, 2'd0);
      step(1, 0, 0, 0, 2'd1, 2'd1);
      step(1, 1, 1, 1, 2'd2, 2'd2);

      // en=0 gap with w toggling holds state
      do_reset();
      step(1, 1, 0, 0, 2'd0, 2'd0);
      step(1, 0, 0, 0, 2'd1, 2'd1);
      for (int i = 0; i < 4; i++) step(0, 1'(i), 0, 0, 2'd2, 2'd2);
      step(1, 1, 1, 1, 2'd2, 2'd2);

      // Every reachable fill/hist with every en/w: z truth table
      for (int k = 0; k <= 2; k++) begin
         for (int h = 0; h < (1 << k); h++) begin
            do_reset();
            for (int i = k - 1; i >= 0; i--) begin
               @(negedge clk);
               en = 1'b1;
               w  = h[i];
               @(posedge clk);
               #1;
            end
            @(negedge clk);
            for (int e = 0; e < 2; e++) begin
               for (int b = 0; b < 2; b++) begin
                  en = 1'(e);
                  w  = 1'(b);
                  sb.push_back('{1'(e == 1 && k == 2 && h == 2 && b == 1),
                                 1'(e == 1 && k == 2 && h == 2 && b == 1),
                                 2'(k), 2'(k)});
                  #1;
                  x = sb.pop_front();
                  chk("tt_z_ovl",    8'(z_o),    8'(x.zo));
                  chk("tt_z_novl",   8'(z_n),    8'(x.zn));
                  chk("tt_fill_ovl", 8'(fill_o), 8'(x.fo));
               end
            end
            en = 1'b0;
            w  = 1'b0;
         end
      end

`ifdef MATCH_COUNT_EN
      begin
         int fn_tab[11];
         int m_o;
         int m_n;
         fn_tab = '{0, 1, 2, 0, 1, 2, 2, 0, 1, 2, 2};
         m_o = 0;
         m_n = 0;
         do_reset();
         chk("cnt_rst", 8'(mc_o), 8'h00);
         for (int i = 0; i < 11; i++) begin
            logic mo;
            logic mn;
            mo = 1'(i >= 2 && (i % 2) == 0);
            mn = 1'(i == 2 || i == 6 || i == 10);
            step(1, 1'((i % 2) == 0), mo, mn, (i < 2) ? 2'(i) : 2'd2, 2'(fn_tab[i]));
            if (mo) m_o++;
            if (mn) m_n++;
            chk("cnt_ovl",  8'(mc_o), 8'((m_o > 3) ? 3 : m_o));
            chk("cnt_novl", mc_n,     8'(m_n));
         end
         step(1, 0, 0, 0, 2'd2, 2'd0);
         count_clr = 1'b1;
         step(1, 1, 1, 0, 2'd2, 2'd1);
         count_clr = 1'b0;
         chk("cnt_clr_ovl",  8'(mc_o), 8'h00);
         chk("cnt_clr_novl", mc_n,     8'h00);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
